// File: rtl/core_pkg.sv
// Shared types and constants for the block-transfer micro-op sequencer.
// Block modes are encoded as the {P,U} bit pair taken from the instruction.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } seq_state_t;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        DA = 2'b00,
        IA = 2'b01,
        DB = 2'b10,
        IB = 2'b11
    } block_mode_t;

endpackage

// File: rtl/ldm_stm_sequencer_lsb.sv
// Priority encoder: index of the lowest set bit plus a one-hot mask of that
// bit, so the caller can strip it from the remaining register list.
module lowest_set_bit #(
    parameter int W  = 16,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  bits,
    output logic [IW-1:0] index,
    output logic [W-1:0]  clear_mask
);

    // Two's complement isolates the lowest set bit.
    assign clear_mask = bits & (~bits + W'(1));

    always_comb begin
        index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Expands one LDM/STM instruction into single-register micro-ops, one per
// accepted cycle, followed by an optional base-writeback micro-op.
module ldm_stm_sequencer #(
    parameter int NREGS      = 16,
    parameter int WORD_BYTES = core_pkg::WORD_BYTES,
    parameter int IDXW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [NREGS-1:0] RegList,
    input  logic             PBit,
    input  logic             UBit,
    input  logic             WBit,
    input  logic             LBit,
    input  logic             Stall,
    output logic             Busy,
    output logic             UopValid,
    output logic [IDXW-1:0]  UopReg,
    output logic [31:0]      UopOffset,
    output logic             UopLoad,
    output logic             UopWb,
    output logic             UopLast
);
    import core_pkg::*;

    localparam int CW = $clog2(NREGS + 1);
    localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

    seq_state_t       state_reg;
    logic [NREGS-1:0] list_reg;
    logic [CW-1:0]    n_reg;
    logic [CW-1:0]    k_reg;
    logic [31:0]      base_off_reg;
    logic             u_reg;
    logic             w_reg;

    logic [NREGS-1:0] sel_list;
    logic [NREGS-1:0] lsb_mask;
    logic [IDXW-1:0]  lsb_index;
    logic [NREGS-1:0] rem_after;
    logic [CW-1:0]    start_n;
    logic [31:0]      start_base;
    logic [31:0]      n_bytes;

    // In IDLE the encoder looks at the incoming list so the first micro-op
    // can be presented straight out of the latch edge.
    assign sel_list  = (state_reg == IDLE) ? RegList : list_reg;
    assign rem_after = sel_list & ~lsb_mask;
    assign start_n   = CW'($countones(RegList));
    assign n_bytes   = STRIDE * 32'(n_reg);

    lowest_set_bit #(
        .W (NREGS),
        .IW(IDXW)
    ) u_lsb (
        .bits      (sel_list),
        .index     (lsb_index),
        .clear_mask(lsb_mask)
    );

    always_comb begin
        start_base = '0;
        unique case (block_mode_t'({PBit, UBit}))
            IA:      start_base = '0;
            IB:      start_base = STRIDE;
            DA:      start_base = STRIDE - STRIDE * 32'(start_n);
            DB:      start_base = -(STRIDE * 32'(start_n));
            default: start_base = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            list_reg     <= '0;
            n_reg        <= '0;
            k_reg        <= '0;
            base_off_reg <= '0;
            u_reg        <= 1'b0;
            w_reg        <= 1'b0;
            Busy         <= 1'b0;
            UopValid     <= 1'b0;
            UopReg       <= '0;
            UopOffset    <= '0;
            UopLoad      <= 1'b0;
            UopWb        <= 1'b0;
            UopLast      <= 1'b0;
        end else if (!Stall) begin
            unique case (state_reg)
                IDLE: begin
                    if (Start && (RegList != '0)) begin
                        state_reg    <= XFER;
                        list_reg     <= rem_after;
                        n_reg        <= start_n;
                        k_reg        <= CW'(1);
                        base_off_reg <= start_base;
                        u_reg        <= UBit;
                        w_reg        <= WBit;
                        Busy         <= 1'b1;
                        UopValid     <= 1'b1;
                        UopReg       <= lsb_index;
                        UopOffset    <= start_base;
                        UopLoad      <= LBit;
                        UopWb        <= 1'b0;
                        UopLast      <= (rem_after == '0) && !WBit;
                    end
                end
                XFER: begin
                    if (list_reg != '0) begin
                        list_reg  <= rem_after;
                        k_reg     <= k_reg + CW'(1);
                        UopReg    <= lsb_index;
                        UopOffset <= base_off_reg + STRIDE * 32'(k_reg);
                        UopLast   <= (rem_after == '0) && !w_reg;
                    end else if (w_reg) begin
                        state_reg <= WB;
                        UopReg    <= '0;
                        UopOffset <= u_reg ? n_bytes : -n_bytes;
                        UopWb     <= 1'b1;
                        UopLast   <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        Busy      <= 1'b0;
                        UopValid  <= 1'b0;
                        UopReg    <= '0;
                        UopOffset <= '0;
                        UopLoad   <= 1'b0;
                        UopLast   <= 1'b0;
                    end
                end
                WB: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                    UopValid  <= 1'b0;
                    UopReg    <= '0;
                    UopOffset <= '0;
                    UopLoad   <= 1'b0;
                    UopWb     <= 1'b0;
                    UopLast   <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized check of ldm_stm_sequencer against a queue-based model that
// expands each block transfer into its expected micro-op list.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [15:0] RegList;
    logic        PBit, UBit, WBit, LBit;
    logic        Stall;
    logic        Busy, UopValid, UopLoad, UopWb, UopLast;
    logic [3:0]  UopReg;
    logic [31:0] UopOffset;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] off;
        logic        wb;
        logic        last;
    } uop_t;

    always #5 clk = ~clk;

    ldm_stm_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .RegList  (RegList),
        .PBit     (PBit),
        .UBit     (UBit),
        .WBit     (WBit),
        .LBit     (LBit),
        .Stall    (Stall),
        .Busy     (Busy),
        .UopValid (UopValid),
        .UopReg   (UopReg),
        .UopOffset(UopOffset),
        .UopLoad  (UopLoad),
        .UopWb    (UopWb),
        .UopLast  (UopLast)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"},  32'(Busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(UopValid), 32'd0);
        check_eq({tag, "_reg"},   32'(UopReg), 32'd0);
        check_eq({tag, "_off"},   UopOffset, 32'd0);
        check_eq({tag, "_load"},  32'(UopLoad), 32'd0);
        check_eq({tag, "_wb"},    32'(UopWb), 32'd0);
        check_eq({tag, "_last"},  32'(UopLast), 32'd0);
    endtask

    // Expected micro-ops: registers ascend, addresses ascend by one word from
    // the lowest address of the block; writeback moves the base by 4n.
    function automatic void build_model(input logic [15:0] rl, input logic p, input logic u,
                                        input logic w, ref uop_t q[$]);
        int n = $countones(rl);
        int lowest;
        int k = 0;
        uop_t e;
        q.delete();
        if (u) lowest = p ? 4 : 0;
        else   lowest = p ? -4 * n : -4 * n + 4;
        for (int r = 0; r < 16; r++) begin
            if (rl[r]) begin
                e.r = 4'(r);
                e.off = 32'(lowest + 4 * k);
                e.wb = 1'b0;
                e.last = (k == n - 1) && !w;
                q.push_back(e);
                k++;
            end
        end
        if (w && n > 0) begin
            e.r = 4'd0;
            e.off = u ? 32'(4 * n) : 32'(-4 * n);
            e.wb = 1'b1;
            e.last = 1'b1;
            q.push_back(e);
        end
    endfunction

    // stall_mode: 0 none, 1 random, 2 two-cycle stall on the 2nd micro-op.
    // abort_at >= 0 pulses async reset while that micro-op is presented.
    task automatic run_seq(input string name, input logic [15:0] rl, input logic p,
                           input logic u, input logic w, input logic l,
                           input int stall_mode, input int abort_at);
        uop_t q[$];
        int idx = 0;
        int hold = 0;
        logic s;
        build_model(rl, p, u, w, q);
        @(negedge clk);
        Start = 1'b1; RegList = rl; PBit = p; UBit = u; WBit = w; LBit = l; Stall = 1'b0;
        @(negedge clk);
        while (q.size() > 0) begin
            check_eq({name, "_valid"}, 32'(UopValid), 32'd1);
            check_eq({name, "_busy"},  32'(Busy), 32'd1);
            check_eq({name, "_reg"},   32'(UopReg), 32'(q[0].r));
            check_eq({name, "_off"},   UopOffset, q[0].off);
            check_eq({name, "_wb"},    32'(UopWb), 32'(q[0].wb));
            check_eq({name, "_last"},  32'(UopLast), 32'(q[0].last));
            check_eq({name, "_load"},  32'(UopLoad), 32'(l));
            $display("%s uop %0d: reg=%0d off=0x%08h wb=%0b last=%0b stall_hold=%0d",
                     name, idx, UopReg, UopOffset, UopWb, UopLast, hold);
            if (idx == abort_at) begin
                #2 reset = 1'b1;
                #1 check_quiet({name, "_abort"});
                $display("%s async reset applied during uop %0d", name, idx);
                @(negedge clk);
                Start = 1'b0; Stall = 1'b0;
                reset = 1'b0;
                return;
            end
            // Competing instruction while busy; must be ignored.
            Start = 1'($urandom_range(0, 1));
            RegList = 16'($urandom);
            PBit = 1'($urandom); UBit = 1'($urandom); WBit = 1'($urandom); LBit = 1'($urandom);
            case (stall_mode)
                1:       s = ($urandom_range(0, 3) == 0);
                2:       s = (idx == 1) && (hold < 2);
                default: s = 1'b0;
            endcase
            Stall = s;
            @(negedge clk);
            if (s) hold++;
            else begin
                void'(q.pop_front());
                idx++;
                hold = 0;
            end
        end
        Start = 1'b0; Stall = 1'b0;
        check_quiet({name, "_done"});
        @(negedge clk);
        check_quiet({name, "_idle"});
        $display("%s complete: %0d micro-ops", name, idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rl;
        reset = 1'b1; Start = 1'b0; RegList = '0; Stall = 1'b0;
        PBit = 1'b0; UBit = 1'b0; WBit = 1'b0; LBit = 1'b0;
        #1 check_quiet("reset");
        @(negedge clk); @(negedge clk);
        check_quiet("reset_hold");
        reset = 1'b0;

        run_seq("stm_ia",      16'h000E, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1);
        run_seq("ldm_db_wb",   16'h8001, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1);
        run_seq("ldm_ib_all",  16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, -1);
        run_seq("stm_ia_stl",  16'h000E, 1'b0, 1'b1, 1'b0, 1'b0, 2, -1);
        run_seq("ldm_db_all",  16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1);
        run_seq("stm_da",      16'h0109, 1'b0, 1'b0, 1'b1, 1'b0, 1, -1);
        run_seq("empty",       16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1);
        run_seq("ib_abort",    16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, 5);
        check_quiet("post_abort");
        run_seq("after_abort", 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 0, -1);

        for (int t = 0; t < 40; t++) begin
            rl = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 4) == 0) rl = 16'h0001 << $urandom_range(0, 15);
            run_seq($sformatf("rnd%0d", t), rl, 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Micro-op sequencer for block transfers (LDM/STM) in the pipelined core.
- Latches the register list and addressing-mode bits of one block-transfer instruction, then emits one single-register transfer micro-op per cycle.
- Each micro-op carries the register number and the 32-bit byte offset that replaces the extender's immediate output in Execute.
- When writeback is requested, emits a final base-update micro-op. Busy stalls Fetch/Decode while a sequence is in flight.

Parameters:
- NREGS, 16, width of the register list; register index width is clog2(NREGS).
- WORD_BYTES, 4, byte stride between consecutive transfers.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- Start  input  1  Decode holds a valid block-transfer instruction
- RegList  input  16  Instr[15:0] register list
- PBit  input  1  pre-index (Instr[24])
- UBit  input  1  up/increment (Instr[23])
- WBit  input  1  base writeback (Instr[21])
- LBit  input  1  load=1 / store=0 (Instr[20])
- Stall  input  1  Execute stalled; hold current micro-op
- Busy  output  1  sequence in flight; Decode must stall
- UopValid  output  1  micro-op outputs valid this cycle
- UopReg  output  4  register transferred by this micro-op
- UopOffset  output  32  signed byte offset from base (two's complement)
- UopLoad  output  1  copy of latched LBit
- UopWb  output  1  this micro-op is the base-writeback op
- UopLast  output  1  final micro-op of the sequence

Behaviour:
- Reset (async, any time): state IDLE. Busy, UopValid, UopWb and UopLast are 0. UopReg is 0, UopOffset is 0, UopLoad is 0. Latched list is cleared.
- Reset mid-sequence: aborts immediately; no further micro-ops are emitted.
- States:
  - IDLE: Start=1 with RegList≠0 latches RegList, P, U, W, L; computes n = popcount(RegList); goes to XFER.
  - IDLE: Start=1 with RegList=0 is ignored; stays IDLE, no micro-ops.
  - XFER: one transfer micro-op per non-stalled cycle.
  - WB: a single writeback micro-op.
- Latency:
  - Start sampled on edge 0.
  - First micro-op presented in the cycle after edge 0, with Busy=1 and UopValid=1.
  - All outputs are registered.
- XFER ordering:
  - Registers are emitted in ascending index order. Each cycle takes the lowest set bit of the remaining list, then clears it.
  - k = number already emitted, 0..n-1.
  - UopOffset = base_off + WORD_BYTES*k, where base_off is:
    - IA (P=0,U=1): 0
    - IB (P=1,U=1): +4
    - DA (P=0,U=0): −4n+4
    - DB (P=1,U=0): −4n
  - All offset arithmetic is 32-bit two's complement; n=16 DB gives first offset 0xFFFFFFC0.
- On the last transfer:
  - W=0: UopLast=1, then return to IDLE.
  - W=1: UopLast=0, then go to WB.
- WB state:
  - Outputs: UopValid=1, UopWb=1, UopLast=1.
  - UopOffset = +4n if U=1, else −4n.
  - UopReg = 0; the pipeline uses Rn from its own latch.
  - Then return to IDLE.
- Stall=1: state, remaining list, k and all outputs hold unchanged; the micro-op is re-presented next cycle.
- Busy:
  - Busy=1 whenever state≠IDLE. It falls in the cycle after the last micro-op is accepted (Stall=0).
  - Start while Busy=1 is ignored.
  - Start in the same cycle the last micro-op is accepted is also ignored; Decode is still stalled and re-presents the instruction.
- IDLE outputs: UopValid=0, UopWb=0, UopLast=0; UopReg and UopOffset are 0.

Decomposition:
- Shared package (core_pkg) holds:
  - Enum seq_state_t {IDLE, XFER, WB}.
  - Constant WORD_BYTES.
  - Block-mode encodings IA, IB, DA, DB as a 2-bit {P,U} type.
- Sub-module lowest_set_bit: combinational 16-bit priority encoder. Outputs index[3:0] and a one-hot clear mask; reused by the popcount/sequence path.
- Popcount is computed inline at latch time.

Test Plan:
- STM IA, RegList=0x000E, P=0, U=1, W=0 → 3 micro-ops over cycles 1..3:
  - (r1, 0), (r2, 4), (r3, 8); UopLast on r3.
  - Busy high cycles 1..3, low cycle 4.
- LDM DB with writeback, RegList=0x8001, P=1, U=0, W=1 → (r0, 0xFFFFFFF8), (r15, 0xFFFFFFFC), then WB op with offset 0xFFFFFFF8, UopWb=1, UopLast=1.
- LDM IB, RegList=0xFFFF, W=1 → 16 transfers:
  - Offsets 4..64, registers r0..r15 in order.
  - WB offset 64; 17 micro-ops in total.
- Stall asserted for 2 cycles during the 2nd micro-op of the IA case → (r2, 4) is held for 3 cycles; sequence then completes with (r3, 8); no register skipped or duplicated.
- Start with RegList=0 → Busy stays 0 and UopValid stays 0. Start asserted while Busy=1 → ignored; in-flight sequence unaffected.
- Async reset pulse mid-XFER of the 0xFFFF case → all outputs 0 immediately, without waiting for a clock edge. A subsequent Start with RegList=0x0001, IA, begins a fresh sequence: (r0, 0).
